// File: rtl/ff_fifo_any_depth.sv
// Single-clock show-ahead FIFO of arbitrary depth (>= 2).
// Occupancy count, programmable almost flags, sticky overflow/underflow.
module ff_fifo_any_depth #(
  parameter int width            = 8,
  parameter int depth            = 6,
  parameter int almost_full_lvl  = depth - 1,
  parameter int almost_empty_lvl = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [width-1:0]           write_data,
  output logic [width-1:0]           read_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);
  localparam logic [PW-1:0] LAST = PW'(depth - 1);

  if (depth < 2) begin : g_chk_depth
    $error("ff_fifo_any_depth: depth must be >= 2");
  end
  if (almost_full_lvl < 1 || almost_full_lvl > depth) begin : g_chk_af
    $error("ff_fifo_any_depth: almost_full_lvl out of 1..depth");
  end
  if (almost_empty_lvl < 0 || almost_empty_lvl >= depth) begin : g_chk_ae
    $error("ff_fifo_any_depth: almost_empty_lvl out of 0..depth-1");
  end

  logic [width-1:0] mem_q [depth];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          push_ok;
  logic          pop_ok;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(depth));
  assign almost_full  = (count_q >= CW'(almost_full_lvl));
  assign almost_empty = (count_q <= CW'(almost_empty_lvl));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign read_data    = mem_q[rd_ptr_q];

  // Accept decisions, pointer/count next state and sticky error flags
  always_comb begin
    push_ok  = push & (~full | pop);
    pop_ok   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
    // a fresh error in the same cycle as clr_err keeps the flag set
    ovf_d = (ovf_q & ~clr_err) | (push & full & ~pop);
    unf_d = (unf_q & ~clr_err) | (pop & empty);
  end

  // Control state register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array, written on accepted push; never reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= write_data;
    end
  end

endmodule
